// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline sequencer
package pipe_pkg;

   localparam int REG_W = 3;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      DRAIN    = 2'd2,
      HALTED   = 2'd3
   } state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - decoded control fields in, pipeline enables/flushes out
interface pipe_ctrl_if
   import pipe_pkg::*;
#(
   parameter int CNT_W = 16
);
   logic [REG_W-1:0] FD_rs;
   logic [REG_W-1:0] FD_rt;
   logic             FD_rs_vld;
   logic             FD_rt_vld;
   logic             DX_memRead;
   logic             DX_regWrite;
   logic [REG_W-1:0] DX_writeReg;
   logic             branch_taken;
   logic             XM_memRead;
   logic             XM_memWrite;
   logic             XM_halt;
   logic             mem_done;

   logic             pc_en;
   logic             FD_en;
   logic             DX_en;
   logic             XM_en;
   logic             MW_en;
   logic             FD_flush;
   logic             DX_flush;
   logic             MW_flush;
   logic             mem_en;
   logic             halt_out;
   logic [1:0]       state;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output FD_rs, FD_rt, FD_rs_vld, FD_rt_vld, DX_memRead, DX_regWrite,
             DX_writeReg, branch_taken, XM_memRead, XM_memWrite, XM_halt, mem_done,
      input  pc_en, FD_en, DX_en, XM_en, MW_en, FD_flush, DX_flush, MW_flush,
             mem_en, halt_out, state, stall_cnt
   );

   modport slave (
      input  FD_rs, FD_rt, FD_rs_vld, FD_rt_vld, DX_memRead, DX_regWrite,
             DX_writeReg, branch_taken, XM_memRead, XM_memWrite, XM_halt, mem_done,
      output pc_en, FD_en, DX_en, XM_en, MW_en, FD_flush, DX_flush, MW_flush,
             mem_en, halt_out, state, stall_cnt
   );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// rtl/pipe_ctrl_hazard_detect.sv - load-use comparator between decode sources and execute load
module hazard_detect
   import pipe_pkg::*;
(
   input  logic [REG_W-1:0] i_fd_rs,
   input  logic [REG_W-1:0] i_fd_rt,
   input  logic             i_fd_rs_vld,
   input  logic             i_fd_rt_vld,
   input  logic             i_dx_mem_read,
   input  logic             i_dx_reg_write,
   input  logic [REG_W-1:0] i_dx_write_reg,
   output logic             o_load_use
);
   logic w_rs_hit;
   logic w_rt_hit;

   // Only sources that are actually read can create a hazard.
   assign w_rs_hit   = i_fd_rs_vld & (i_fd_rs == i_dx_write_reg);
   assign w_rt_hit   = i_fd_rt_vld & (i_fd_rt == i_dx_write_reg);
   assign o_load_use = i_dx_mem_read & i_dx_reg_write & (w_rs_hit | w_rt_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - five-stage pipeline sequencer: hazards, squashes, memory waits, halt
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic       clk,
   input  logic       rst,
   pipe_ctrl_if.slave bus
);
   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_stall_cnt;
   logic             r_halt;
   logic             w_load_use;
   logic             w_mem_op;
   logic             w_pc_en, w_fd_en, w_dx_en, w_xm_en, w_mw_en;
   logic             w_fd_flush, w_dx_flush, w_mw_flush, w_mem_en;

   hazard_detect u_hazard (
      .i_fd_rs        (bus.FD_rs),
      .i_fd_rt        (bus.FD_rt),
      .i_fd_rs_vld    (bus.FD_rs_vld),
      .i_fd_rt_vld    (bus.FD_rt_vld),
      .i_dx_mem_read  (bus.DX_memRead),
      .i_dx_reg_write (bus.DX_regWrite),
      .i_dx_write_reg (bus.DX_writeReg),
      .o_load_use     (w_load_use)
   );

   assign w_mem_op = bus.XM_memRead | bus.XM_memWrite;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= RUN;
         r_halt  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_halt  <= (w_next == HALTED);
      end
   end

   always_comb begin
      w_next     = r_state;
      w_pc_en    = 1'b0;
      w_fd_en    = 1'b0;
      w_dx_en    = 1'b0;
      w_xm_en    = 1'b0;
      w_mw_en    = 1'b0;
      w_fd_flush = 1'b0;
      w_dx_flush = 1'b0;
      w_mw_flush = 1'b0;
      w_mem_en   = 1'b0;
      case (r_state)
         RUN: begin
            if (w_mem_op && !bus.mem_done) begin
               w_mem_en = 1'b1;
               w_next   = MEM_WAIT;
            end else begin
               // A same-cycle hit issues the strobe and falls through to the normal rows.
               w_mem_en = w_mem_op;
               if (bus.XM_halt) begin
                  w_xm_en    = 1'b1;
                  w_mw_en    = 1'b1;
                  w_fd_flush = 1'b1;
                  w_dx_flush = 1'b1;
                  w_next     = DRAIN;
               end else if (bus.branch_taken) begin
                  {w_pc_en, w_fd_en, w_dx_en, w_xm_en, w_mw_en} = 5'b11111;
                  w_fd_flush = 1'b1;
                  w_dx_flush = 1'b1;
               end else if (w_load_use) begin
                  {w_dx_en, w_xm_en, w_mw_en} = 3'b111;
                  w_dx_flush = 1'b1;
               end else begin
                  {w_pc_en, w_fd_en, w_dx_en, w_xm_en, w_mw_en} = 5'b11111;
               end
            end
         end
         MEM_WAIT: begin
            if (bus.mem_done) begin
               {w_pc_en, w_fd_en, w_dx_en, w_xm_en, w_mw_en} = 5'b11111;
               w_next = RUN;
            end else begin
               // Keep writeback from retiring the same instruction again.
               w_mw_flush = 1'b1;
            end
         end
         DRAIN: begin
            w_xm_en    = 1'b1;
            w_mw_en    = 1'b1;
            w_dx_flush = 1'b1;
            w_next     = HALTED;
         end
         HALTED: w_next = HALTED;
         default: w_next = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cnt <= '0;
      end else if (!w_pc_en && (r_state != HALTED) && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign bus.pc_en     = rst & w_pc_en;
   assign bus.FD_en     = rst & w_fd_en;
   assign bus.DX_en     = rst & w_dx_en;
   assign bus.XM_en     = rst & w_xm_en;
   assign bus.MW_en     = rst & w_mw_en;
   assign bus.FD_flush  = rst & w_fd_flush;
   assign bus.DX_flush  = rst & w_dx_flush;
   assign bus.MW_flush  = rst & w_mw_flush;
   assign bus.mem_en    = rst & w_mem_en;
   assign bus.halt_out  = r_halt;
   assign bus.state     = r_state;
   assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed and randomized self-checking bench for pipe_ctrl
module tb_pipe_ctrl;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = 15;

   // Output vector order: {pc,FD,DX,XM,MW enables, FD,DX,MW flushes, mem_en}
   localparam logic [15:0] P_NONE  = 16'h000;
   localparam logic [15:0] P_ALL   = 16'h1F0;
   localparam logic [15:0] P_MISS  = 16'h001;
   localparam logic [15:0] P_HIT   = 16'h1F1;
   localparam logic [15:0] P_WAIT  = 16'h002;
   localparam logic [15:0] P_LU    = 16'h074;
   localparam logic [15:0] P_BR    = 16'h1FC;
   localparam logic [15:0] P_HALT  = 16'h03C;
   localparam logic [15:0] P_DRAIN = 16'h034;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   tests = 0;
   int   fails = 0;
   int   pulses;
   int   m_state, m_nst, m_cnt;
   logic [15:0] exp_o;

   pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

   pipe_ctrl #(.CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] outs();
      return 16'({bus.pc_en, bus.FD_en, bus.DX_en, bus.XM_en, bus.MW_en,
                  bus.FD_flush, bus.DX_flush, bus.MW_flush, bus.mem_en});
   endfunction

   task automatic clear_in();
      bus.FD_rs = '0; bus.FD_rt = '0; bus.FD_rs_vld = 0; bus.FD_rt_vld = 0;
      bus.DX_memRead = 0; bus.DX_regWrite = 0; bus.DX_writeReg = '0;
      bus.branch_taken = 0; bus.XM_memRead = 0; bus.XM_memWrite = 0;
      bus.XM_halt = 0; bus.mem_done = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_regs(input string tag, input int st, input int cnt, input logic halt);
      chk({tag, "_state"}, 16'(bus.state), 16'(st));
      chk({tag, "_stall"}, 16'(bus.stall_cnt), 16'(cnt));
      chk({tag, "_halt"}, 16'(bus.halt_out), 16'(halt));
   endtask

   // Reference: decides what each pipeline register does from the priority rules.
   function automatic logic [15:0] ref_model(input int st, output int nst);
      int   src[2];
      bit   rd[2];
      bit   load_use;
      bit   mem_op;
      logic [15:0] r;
      src[0] = int'(bus.FD_rs); rd[0] = bus.FD_rs_vld;
      src[1] = int'(bus.FD_rt); rd[1] = bus.FD_rt_vld;
      load_use = 0;
      foreach (src[i])
         if (rd[i] && bus.DX_memRead && bus.DX_regWrite && src[i] == int'(bus.DX_writeReg))
            load_use = 1;
      mem_op = bus.XM_memRead || bus.XM_memWrite;
      nst = st;
      if (st == 0) begin
         if (mem_op && !bus.mem_done) begin
            nst = 1;
            return P_MISS;
         end
         if (bus.XM_halt) begin
            nst = 2;
            r = P_HALT;
         end else if (bus.branch_taken) r = P_BR;
         else if (load_use)             r = P_LU;
         else                           r = P_ALL;
         return mem_op ? (r | 16'h001) : r;
      end else if (st == 1) begin
         if (bus.mem_done) begin
            nst = 0;
            return P_ALL;
         end
         return P_WAIT;
      end else if (st == 2) begin
         nst = 3;
         return P_DRAIN;
      end
      return P_NONE;
   endfunction

   initial begin
      clear_in();
      // Reset held, with a memory op pending: everything stays low.
      bus.XM_memRead = 1;
      tick(); tick();
      chk("rst_outs", outs(), P_NONE);
      chk_regs("rst", 0, 0, 0);
      clear_in();
      rst = 1;
      #1 chk("rel_outs", outs(), P_ALL);
      tick();
      chk("idle_outs", outs(), P_ALL);
      chk_regs("idle", 0, 0, 0);

      // Load-use on rs.
      bus.DX_memRead = 1; bus.DX_regWrite = 1; bus.DX_writeReg = 3'd3;
      bus.FD_rs = 3'd3; bus.FD_rs_vld = 1;
      #1 chk("lu_outs", outs(), P_LU);
      tick();
      chk_regs("lu", 0, 1, 0);
      bus.FD_rs_vld = 0;
      #1 chk("lu_novld_outs", outs(), P_ALL);
      tick();
      chk_regs("lu_novld", 0, 1, 0);
      clear_in();

      // Miss with mem_done three cycles after the request.
      pulses = 0;
      bus.XM_memRead = 1;
      #1 chk("miss_req", outs(), P_MISS);
      pulses += int'(bus.mem_en);
      tick();
      for (int i = 0; i < 2; i++) begin
         chk("miss_wait_state", 16'(bus.state), 16'd1);
         chk("miss_wait_outs", outs(), P_WAIT);
         pulses += int'(bus.mem_en);
         tick();
      end
      chk("miss_last_state", 16'(bus.state), 16'd1);
      bus.mem_done = 1;
      #1 chk("miss_done_outs", outs(), P_ALL);
      pulses += int'(bus.mem_en);
      tick();
      chk_regs("miss_end", 0, 4, 0);
      chk("miss_pulses", 16'(pulses), 16'd1);
      clear_in();

      // Same-cycle hit costs nothing.
      bus.XM_memWrite = 1; bus.mem_done = 1;
      #1 chk("hit_outs", outs(), P_HIT);
      tick();
      chk_regs("hit", 0, 4, 0);
      clear_in();

      // Branch wins over load-use.
      bus.branch_taken = 1;
      bus.DX_memRead = 1; bus.DX_regWrite = 1; bus.DX_writeReg = 3'd5;
      bus.FD_rt = 3'd5; bus.FD_rt_vld = 1;
      #1 chk("br_lu_outs", outs(), P_BR);
      tick();
      chk_regs("br_lu", 0, 4, 0);
      clear_in();

      // Halt together with a miss: the memory op goes first.
      bus.XM_halt = 1; bus.XM_memRead = 1;
      #1 chk("halt_mem_outs", outs(), P_MISS);
      tick();
      chk_regs("halt_mem_wait", 1, 5, 0);
      bus.mem_done = 1;
      #1 chk("halt_mem_done", outs(), P_ALL);
      tick();
      chk_regs("halt_mem_end", 0, 5, 0);
      clear_in();

      // Randomized run against the reference model.
      m_state = 0;
      m_cnt   = 5;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 31) == 0 || (m_state == 3 && $urandom_range(0, 2) == 0)) begin
            rst = 0;
            bus.mem_done = 1;
            #1;
            chk("rnd_rst_outs", outs(), P_NONE);
            chk_regs("rnd_rst", 0, 0, 0);
            tick();
            rst = 1;
            m_state = 0;
            m_cnt   = 0;
         end
         bus.FD_rs        = 3'($urandom_range(0, 3));
         bus.FD_rt        = 3'($urandom_range(0, 3));
         bus.DX_writeReg  = 3'($urandom_range(0, 3));
         bus.FD_rs_vld    = 1'($urandom_range(0, 1));
         bus.FD_rt_vld    = 1'($urandom_range(0, 1));
         bus.DX_memRead   = 1'($urandom_range(0, 1));
         bus.DX_regWrite  = 1'($urandom_range(0, 1));
         bus.branch_taken = ($urandom_range(0, 3) == 0);
         bus.XM_memRead   = ($urandom_range(0, 4) == 0);
         bus.XM_memWrite  = ($urandom_range(0, 5) == 0);
         bus.XM_halt      = ($urandom_range(0, 15) == 0);
         bus.mem_done     = ($urandom_range(0, 2) == 0);
         #1;
         exp_o = ref_model(m_state, m_nst);
         chk("rnd_outs", outs(), exp_o);
         tick();
         if (!exp_o[8] && m_state != 3 && m_cnt < CNT_MAX) m_cnt++;
         m_state = m_nst;
         chk_regs("rnd", m_state, m_cnt, m_state == 3);
      end

      // Clean restart, then halt draining.
      clear_in();
      rst = 0;
      tick();
      rst = 1;
      bus.XM_halt = 1;
      #1 chk("halt_outs", outs(), P_HALT);
      tick();
      chk_regs("drain", 2, 1, 0);
      bus.XM_halt = 0;
      #1 chk("drain_outs", outs(), P_DRAIN);
      tick();
      for (int i = 0; i < 10; i++) begin
         chk("halted_outs", outs(), P_NONE);
         chk_regs("halted", 3, 2, 1);
         tick();
      end
      #2 rst = 0;
      #1 chk_regs("halted_rst", 0, 0, 0);
      chk("halted_rst_outs", outs(), P_NONE);
      tick();
      rst = 1;

      // Long miss drives the stall counter into saturation.
      bus.XM_memRead = 1;
      for (int i = 0; i < 20; i++) tick();
      chk_regs("sat_wait", 1, CNT_MAX, 0);
      bus.mem_done = 1;
      tick();
      chk_regs("sat_end", 0, CNT_MAX, 0);
      clear_in();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
